// File: rtl/sgmii_rx_frame_pkg.sv
// Shared types and line constants for the SGMII receive path.
package sgmii_pkg;
   typedef enum logic [1:0] {HUNT = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2} state_e;

   localparam logic [9:0] CODE_D21_2    = 10'b1010100101;
   localparam logic [9:0] CODE_D21_6    = 10'b1010100110;
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
endpackage

// File: rtl/sgmii_rx_frame_decode.sv
// Combinational 8b10b decoder; datain[9] is bit 'a', datain[0] is bit 'j'.
// Both disparity variants decode; running disparity is tracked, not checked.
module sgmii_rx_frame_decode (
   input  logic [9:0] datain,
   input  logic       dispin,
   output logic [8:0] dataout,
   output logic       dispout,
   output logic       code_err
);
   logic [5:0] c6;
   logic [3:0] c4;
   logic [4:0] d5;
   logic [2:0] d3;
   logic       err6, err4, k28, kx7, rd6;

   assign c6 = datain[9:4];
   assign c4 = datain[3:0];

   always_comb begin
      d5 = 5'd0; err6 = 1'b0; k28 = 1'b0;
      case (c6)
         6'b100111, 6'b011000: d5 = 5'd0;   6'b011101, 6'b100010: d5 = 5'd1;
         6'b101101, 6'b010010: d5 = 5'd2;   6'b110001:            d5 = 5'd3;
         6'b110101, 6'b001010: d5 = 5'd4;   6'b101001:            d5 = 5'd5;
         6'b011001:            d5 = 5'd6;   6'b111000, 6'b000111: d5 = 5'd7;
         6'b111001, 6'b000110: d5 = 5'd8;   6'b100101:            d5 = 5'd9;
         6'b010101:            d5 = 5'd10;  6'b110100:            d5 = 5'd11;
         6'b001101:            d5 = 5'd12;  6'b101100:            d5 = 5'd13;
         6'b011100:            d5 = 5'd14;  6'b010111, 6'b101000: d5 = 5'd15;
         6'b011011, 6'b100100: d5 = 5'd16;  6'b100011:            d5 = 5'd17;
         6'b010011:            d5 = 5'd18;  6'b110010:            d5 = 5'd19;
         6'b001011:            d5 = 5'd20;  6'b101010:            d5 = 5'd21;
         6'b011010:            d5 = 5'd22;  6'b111010, 6'b000101: d5 = 5'd23;
         6'b110011, 6'b001100: d5 = 5'd24;  6'b100110:            d5 = 5'd25;
         6'b010110:            d5 = 5'd26;  6'b110110, 6'b001001: d5 = 5'd27;
         6'b001110:            d5 = 5'd28;  6'b101110, 6'b010001: d5 = 5'd29;
         6'b011110, 6'b100001: d5 = 5'd30;  6'b101011, 6'b010100: d5 = 5'd31;
         6'b001111, 6'b110000: begin d5 = 5'd28; k28 = 1'b1; end
         default:              err6 = 1'b1;
      endcase
   end

   always_comb begin
      d3 = 3'd0; err4 = 1'b0;
      case (c4)
         4'b1011, 4'b0100:                   d3 = 3'd0;
         4'b1001:                            d3 = 3'd1;
         4'b0101:                            d3 = 3'd2;
         4'b1100, 4'b0011:                   d3 = 3'd3;
         4'b1101, 4'b0010:                   d3 = 3'd4;
         4'b1010:                            d3 = 3'd5;
         4'b0110:                            d3 = 3'd6;
         4'b1110, 4'b0001, 4'b0111, 4'b1000: d3 = 3'd7;
         default:                            err4 = 1'b1;
      endcase
   end

   // Alternate x.7 on K23/27/29/30 marks a control character
   assign kx7 = ((c4 == 4'b0111) || (c4 == 4'b1000)) &&
                ((d5 == 5'd23) || (d5 == 5'd27) || (d5 == 5'd29) || (d5 == 5'd30));

   assign rd6      = ($countones(c6) > 3) ? 1'b1 : (($countones(c6) < 3) ? 1'b0 : dispin);
   assign dispout  = ($countones(c4) > 2) ? 1'b1 : (($countones(c4) < 2) ? 1'b0 : rd6);
   assign dataout  = {k28 | kx7, d3, d5};
   assign code_err = err6 | err4;
endmodule

// File: rtl/sgmii_rx_frame.sv
// SGMII receive framer: bit alignment on the preamble, 8b10b decode, and
// footer stripping through a delay line so payload bytes leave with sof/eof.
module sgmii_rx_frame
   import sgmii_pkg::*;
#(
   parameter int MIN_PREAMBLE = 2,
   parameter int FOOTER_LEN   = 12,
   parameter int LEN_W        = 16
) (
   input  logic             ser_sgmii_clk,
   input  logic             reset,
   input  logic             sgmii_rx_p,
   input  logic             sgmii_rx_n,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             rx_sof,
   output logic             rx_eof,
   output logic             rx_err,
   output logic [LEN_W-1:0] frame_len,
   output logic             locked
);
   localparam int ZW = $clog2(FOOTER_LEN + 1);

   state_e                        state_q, state_d;
   logic [9:0]                    sr_q, sr_d;
   logic [3:0]                    cnt_q, cnt_d;
   logic [7:0]                    pre_q, pre_d;
   logic [ZW-1:0]                 zrun_q, zrun_d;
   logic [LEN_W-1:0]              len_q, len_d;
   logic [FOOTER_LEN-1:0][7:0]    dl_q, dl_d;
   logic [FOOTER_LEN-1:0]         dlv_q, dlv_d;
   logic                          rd_q, rd_d, viol_q, viol_d;
   logic [7:0]                    data_q, data_d;
   logic                          valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, err_q, err_d;

   logic [8:0] dec;
   logic       dispout, code_err, bnd, bad, is_zero, foot_done, out_v;
   logic [7:0] out_b;

   sgmii_rx_frame_decode u_dec (
      .datain  (sr_q),
      .dispin  (rd_q),
      .dataout (dec),
      .dispout (dispout),
      .code_err(code_err)
   );

   assign bnd       = (cnt_q == 4'd9);
   assign bad       = code_err | viol_q;
   assign is_zero   = (dec == 9'h000);
   assign foot_done = is_zero && (zrun_q == ZW'(FOOTER_LEN - 1));
   assign out_v     = dlv_q[FOOTER_LEN-1];
   assign out_b     = dl_q[FOOTER_LEN-1];

   always_comb begin
      sr_d    = {sr_q[8:0], sgmii_rx_p};
      cnt_d   = bnd ? 4'd0 : cnt_q + 4'd1;
      // p==n is remembered across the word and judged at its boundary
      viol_d  = (((state_q == HUNT) || bnd) ? 1'b0 : viol_q) | (sgmii_rx_p == sgmii_rx_n);
      state_d = state_q;
      pre_d   = pre_q;
      zrun_d  = zrun_q;
      len_d   = len_q;
      rd_d    = (bnd && (state_q != HUNT)) ? dispout : rd_q;
      dl_d    = dl_q;
      dlv_d   = dlv_q;
      data_d  = data_q;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         HUNT: if (sr_q == CODE_D21_2) begin
            cnt_d   = 4'd0;
            pre_d   = 8'd1;
            state_d = PREAMBLE;
         end
         PREAMBLE: if (bnd) begin
            if (!bad && (dec == {1'b0, PREAMBLE_BYTE})) begin
               pre_d = (&pre_q) ? pre_q : pre_q + 8'd1;
            end else if (!bad && (dec == {1'b0, SFD_BYTE}) && (pre_q >= 8'(MIN_PREAMBLE))) begin
               state_d = DATA;
               dl_d    = '0;
               dlv_d   = '0;
               zrun_d  = '0;
               len_d   = '0;
            end else begin
               state_d = HUNT;
            end
         end
         DATA: if (bnd) begin
            if (bad) begin
               err_d   = 1'b1;
               state_d = HUNT;
               dl_d    = '0;
               dlv_d   = '0;
            end else begin
               dl_d   = {dl_q[FOOTER_LEN-2:0], dec[7:0]};
               dlv_d  = {dlv_q[FOOTER_LEN-2:0], 1'b1};
               zrun_d = is_zero ? zrun_q + 1'b1 : '0;
               if (out_v) begin
                  valid_d = 1'b1;
                  data_d  = out_b;
                  sof_d   = (len_q == '0);
                  len_d   = (&len_q) ? len_q : len_q + 1'b1;
               end
               // Slot leaving on the last footer push is the final payload byte
               if (foot_done) begin
                  eof_d   = out_v;
                  err_d   = ~out_v;
                  state_d = HUNT;
                  dl_d    = '0;
                  dlv_d   = '0;
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge ser_sgmii_clk or negedge reset) begin
      if (!reset) begin
         state_q <= HUNT;
         sr_q    <= '0;
         cnt_q   <= '0;
         pre_q   <= '0;
         zrun_q  <= '0;
         len_q   <= '0;
         dl_q    <= '0;
         dlv_q   <= '0;
         rd_q    <= 1'b0;
         viol_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         zrun_q  <= zrun_d;
         len_q   <= len_d;
         dl_q    <= dl_d;
         dlv_q   <= dlv_d;
         rd_q    <= rd_d;
         viol_q  <= viol_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         err_q   <= err_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign rx_sof    = sof_q;
   assign rx_eof    = eof_q;
   assign rx_err    = err_q;
   assign frame_len = len_q;
   assign locked    = (state_q != HUNT);
endmodule
